// File: rtl/player_input_checker_pkg.sv
// Shared types and helpers for the player input checker and the colour display block.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package player_input_checker_pkg;

  localparam int SEQ_LEN = 33;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    COL_0 = 2'b00,
    COL_1 = 2'b01,
    COL_2 = 2'b10,
    COL_3 = 2'b11
  } colour_t;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    WAIT_PRESS   = 2'b01,
    WAIT_RELEASE = 2'b10
  } checker_state_t;

  // Colour code to the button / lamp bit it drives.
  function automatic logic [3:0] colour_to_onehot(input colour_t c);
    logic [3:0] oh;
    oh = 4'b0001 << c;
    return oh;
  endfunction

  // Button bit back to its colour code; non-one-hot inputs map to COL_0,
  // so callers must qualify with is_onehot().
  function automatic colour_t onehot_to_colour(input logic [3:0] oh);
    colour_t c;
    case (oh)
      4'b0001: c = COL_0;
      4'b0010: c = COL_1;
      4'b0100: c = COL_2;
      4'b1000: c = COL_3;
      default: c = COL_0;
    endcase
    return c;
  endfunction

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/player_input_checker_debouncer.sv
// Synchronizes the raw buttons and publishes a debounced vector once the synchronized value is stable.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples from raw change to deb update.
// Backpressure: none; free-running, every cycle is sampled.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  output logic [3:0] deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       last_smp;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] stable_cnt_nxt;

  // Number of consecutive equal synchronized samples, including the one taken this edge.
  always_comb begin
    stable_cnt_nxt = stable_cnt;
    if (sync2 != last_smp) begin
      stable_cnt_nxt = CNT_ONE;
    end else if (stable_cnt == CNT_MAX) begin
      stable_cnt_nxt = CNT_MAX;
    end else begin
      stable_cnt_nxt = stable_cnt + CNT_ONE;
    end
  end

  // Two-flop synchronizer, sample history, stability counter and debounced output.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 4'b0000;
      sync2      <= 4'b0000;
      last_smp   <= 4'b0000;
      stable_cnt <= '0;
      deb        <= 4'b0000;
    end else begin
      sync1      <= buttons;
      sync2      <= sync1;
      last_smp   <= sync2;
      stable_cnt <= stable_cnt_nxt;
      if (stable_cnt_nxt == CNT_MAX) begin
        deb <= sync2;
      end
    end
  end

endmodule

// File: rtl/player_input_checker.sv
// Cleans the player buttons into a one-hot lamp vector and scores each press against the colour sequence.
// Latency: raw button edge to correct/wrong/round_done pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; pulses are single-cycle and must be consumed by the game FSM when they appear.
module player_input_checker
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SEQ_LEN         = player_input_checker_pkg::SEQ_LEN,
  parameter int IDX_W           = player_input_checker_pkg::IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IDX_W-1:0]        round_len,
  input  logic [3:0]              buttons,
  input  logic [SEQ_LEN-1:0][1:0] segment,
  output logic [3:0]              player_input,
  output logic [IDX_W-1:0]        check_idx,
  output logic                    correct,
  output logic                    wrong,
  output logic                    round_done,
  output logic                    busy
);

  import player_input_checker_pkg::*;

  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(SEQ_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [3:0]       deb;
  logic [3:0]       deb_prev;
  logic             press_evt;
  logic             len_ok;
  logic             is_last;
  colour_t          press_col;
  colour_t          exp_col;

  checker_state_t   state_q;
  checker_state_t   state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] len_nxt;
  logic             correct_nxt;
  logic             wrong_nxt;
  logic             done_nxt;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .buttons (buttons),
    .deb     (deb)
  );

  // A press is only the release-to-single-button transition; chords and
  // one-hot to one-hot slides are ignored.
  assign press_evt = (deb_prev == 4'b0000) && is_onehot(deb);
  assign press_col = onehot_to_colour(deb);
  assign exp_col   = colour_t'(segment[check_idx]);
  assign len_ok    = (round_len != '0) && (round_len <= LEN_MAX);
  assign is_last   = (check_idx == (len_q - IDX_ONE));

  assign busy         = (state_q != IDLE);
  assign player_input = (busy && is_onehot(deb)) ? deb : 4'b0000;

  // Next-state, index and result pulse decode for the entry phase.
  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = check_idx;
    len_nxt     = len_q;
    correct_nxt = 1'b0;
    wrong_nxt   = 1'b0;
    done_nxt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && len_ok) begin
          state_nxt = WAIT_PRESS;
          idx_nxt   = '0;
          len_nxt   = round_len;
        end
      end
      WAIT_PRESS: begin
        if (press_evt) begin
          if (press_col == exp_col) begin
            if (is_last) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              correct_nxt = 1'b1;
              idx_nxt     = check_idx + IDX_ONE;
              state_nxt   = WAIT_RELEASE;
            end
          end else begin
            // check_idx is left pointing at the missed entry for the game FSM.
            wrong_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_RELEASE: begin
        if (deb == 4'b0000) begin
          state_nxt = WAIT_PRESS;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, sequence position, latched length, registered pulses and press-edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      check_idx  <= '0;
      len_q      <= '0;
      correct    <= 1'b0;
      wrong      <= 1'b0;
      round_done <= 1'b0;
      deb_prev   <= 4'b0000;
    end else begin
      state_q    <= state_nxt;
      check_idx  <= idx_nxt;
      len_q      <= len_nxt;
      correct    <= correct_nxt;
      wrong      <= wrong_nxt;
      round_done <= done_nxt;
      deb_prev   <= deb;
    end
  end

endmodule
